// File: rtl/regsel_pkg.sv
// Shared constants and pipeline-stage type for the register-select decoder.
// Default field positions match the 32-bit instruction format.
package regsel_pkg;

    localparam int RS_LSB_DEF = 21;
    localparam int RT_LSB_DEF = 16;
    localparam int RD_LSB_DEF = 11;

    localparam int NREG_MIN  = 2;
    localparam int NREG_MAX  = 64;
    localparam int DPIPE_MIN = 2;
    localparam int DPIPE_MAX = 6;

    // Stage select is sized for the largest register file; unused upper bits stay zero.
    typedef struct packed {
        logic [NREG_MAX-1:0] sel;
        logic                valid;
    } stage_t;

endpackage

// File: rtl/regsel_pipe_decoder_onehot_dec.sv
// Binary index to one-hot decoder, N outputs with exactly one bit set.
module onehot_dec #(
    parameter int N = 32
) (
    input  logic [$clog2(N)-1:0] idx,
    output logic [N-1:0]         onehot
);

    assign onehot = {{(N-1){1'b0}}, 1'b1} << idx;

endmodule

// File: rtl/regsel_pipe_decoder.sv
// Register-select decoder: one-hot read selects, a stall-aware destination pipeline
// and RAW hazard flags. Define REGSEL_ZERO_SUPPRESS_EN to treat r0 as a discard register.
module regsel_pipe_decoder
    import regsel_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int IW     = 32,
    parameter int RS_LSB = RS_LSB_DEF,
    parameter int RT_LSB = RT_LSB_DEF,
    parameter int RD_LSB = RD_LSB_DEF,
    parameter int DPIPE  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IW-1:0]   ibus,
    input  logic            in_valid,
    input  logic            itype,
    input  logic            stall,
    output logic [NREG-1:0] Aselect,
    output logic [NREG-1:0] Bselect,
    output logic            ab_valid,
    output logic [NREG-1:0] Dselect,
    output logic            d_valid,
    output logic            haz_a,
    output logic            haz_b
);

    localparam int AW = $clog2(NREG);

    if (NREG < NREG_MIN || NREG > NREG_MAX || (NREG & (NREG - 1)) != 0) begin : g_bad_nreg
        $error("regsel_pipe_decoder: NREG must be a power of two within range");
    end
    if (DPIPE < DPIPE_MIN || DPIPE > DPIPE_MAX) begin : g_bad_dpipe
        $error("regsel_pipe_decoder: DPIPE out of range");
    end

    logic [AW-1:0]       rs, rt, rd, dest;
    logic [NREG-1:0]     oh_rs, oh_rt, oh_dest;
    logic                dest_keep, rs_can_haz, rt_can_haz;
    logic [NREG_MAX-1:0] inflight;
    stage_t              d [1:DPIPE];

    assign rs   = ibus[RS_LSB +: AW];
    assign rt   = ibus[RT_LSB +: AW];
    assign rd   = ibus[RD_LSB +: AW];
    assign dest = itype ? rt : rd;

    onehot_dec #(.N(NREG)) u_dec_rs   (.idx(rs),   .onehot(oh_rs));
    onehot_dec #(.N(NREG)) u_dec_rt   (.idx(rt),   .onehot(oh_rt));
    onehot_dec #(.N(NREG)) u_dec_dest (.idx(dest), .onehot(oh_dest));

`ifdef REGSEL_ZERO_SUPPRESS_EN
    assign dest_keep  = (dest != '0);
    assign rs_can_haz = (rs != '0);
    assign rt_can_haz = (rt != '0);
`else
    assign dest_keep  = 1'b1;
    assign rs_can_haz = 1'b1;
    assign rt_can_haz = 1'b1;
`endif

    // Write-back stage is excluded: the register file writes before it reads.
    always_comb begin
        inflight = '0;
        for (int i = 1; i < DPIPE; i++) begin
            inflight = inflight | d[i].sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Aselect  <= '0;
            Bselect  <= '0;
            ab_valid <= 1'b0;
            haz_a    <= 1'b0;
            haz_b    <= 1'b0;
            for (int i = 1; i <= DPIPE; i++) begin
                d[i] <= '0;
            end
        end else if (!stall) begin
            Aselect  <= in_valid ? oh_rs : '0;
            Bselect  <= in_valid ? oh_rt : '0;
            ab_valid <= in_valid;
            haz_a    <= in_valid & rs_can_haz & (|(NREG_MAX'(oh_rs) & inflight));
            haz_b    <= in_valid & rt_can_haz & (|(NREG_MAX'(oh_rt) & inflight));
            d[1].sel   <= (in_valid && dest_keep) ? NREG_MAX'(oh_dest) : '0;
            d[1].valid <= in_valid;
            for (int i = 2; i <= DPIPE; i++) begin
                d[i] <= d[i-1];
            end
        end
    end

    assign Dselect = d[DPIPE].sel[NREG-1:0];
    assign d_valid = d[DPIPE].valid;

endmodule

// File: tb/tb_regsel_pipe_decoder.sv
// Scoreboard bench for regsel_pipe_decoder (NREG=32, DPIPE=3): directed cases plus
// randomized traffic against a slot-history reference model.
module tb_regsel_pipe_decoder;

    localparam int NREG  = 32;
    localparam int DPIPE = 3;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        abv;
        logic        ha;
        logic        hb;
        logic [31:0] d;
        logic        dv;
    } exp_t;

    typedef struct {
        int   dest;
        logic valid;
    } hist_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ibus = '0;
    logic        in_valid = 1'b0;
    logic        itype = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] Aselect, Bselect, Dselect;
    logic        ab_valid, d_valid, haz_a, haz_b;

    int    checks = 0;
    int    errors = 0;
    exp_t  pend_q[$];
    exp_t  d_q[$];
    hist_t hist[$];

    regsel_pipe_decoder #(
        .NREG(NREG), .IW(32), .RS_LSB(21), .RT_LSB(16), .RD_LSB(11), .DPIPE(DPIPE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ibus(ibus), .in_valid(in_valid), .itype(itype),
        .stall(stall), .Aselect(Aselect), .Bselect(Bselect), .ab_valid(ab_valid),
        .Dselect(Dselect), .d_valid(d_valid), .haz_a(haz_a), .haz_b(haz_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.a = '0; e.b = '0; e.abv = 0; e.ha = 0; e.hb = 0; e.d = '0; e.dv = 0;
        return e;
    endfunction

    // A source is a hazard if it names the destination of any of the previous DPIPE-1 issue slots.
    function automatic logic in_flight(int src);
`ifdef REGSEL_ZERO_SUPPRESS_EN
        if (src == 0) return 1'b0;
`endif
        foreach (hist[i]) begin
            if (hist[i].valid && hist[i].dest == src) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic applyStimulus(input logic [31:0] ib, input logic it, input logic v, input logic st);
        exp_t  e;
        hist_t h;
        int    rs, rt, rd, dst;
        @(negedge clk);
        rst_n = 1'b1; ibus = ib; itype = it; in_valid = v; stall = st;
        if (!st) begin
            rs  = int'(ib[25:21]);
            rt  = int'(ib[20:16]);
            rd  = int'(ib[15:11]);
            dst = it ? rt : rd;
            e = zero_exp();
            if (v) begin
                e.a   = 32'h1 << rs;
                e.b   = 32'h1 << rt;
                e.abv = 1'b1;
                e.ha  = in_flight(rs);
                e.hb  = in_flight(rt);
                e.d   = 32'h1 << dst;
`ifdef REGSEL_ZERO_SUPPRESS_EN
                if (dst == 0) e.d = '0;
`endif
                e.dv  = 1'b1;
            end
            pend_q.push_back(e);
            h.dest = dst; h.valid = v;
            hist.push_back(h);
            if (hist.size() > DPIPE - 1) void'(hist.pop_front());
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0;
        hist.delete();
        #1;
        checkOutput("rst_Aselect", Aselect, '0);
        checkOutput("rst_Bselect", Bselect, '0);
        checkOutput("rst_Dselect", Dselect, '0);
        checkOutput("rst_ab_valid", {31'b0, ab_valid}, '0);
        checkOutput("rst_d_valid", {31'b0, d_valid}, '0);
        checkOutput("rst_haz", {30'b0, haz_a, haz_b}, '0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: sample just after each rising edge; advancing edges consume one scoreboard slot.
    initial begin
        exp_t held, s, ds;
        logic rst_s, stall_s;
        held = zero_exp();
        forever begin
            @(posedge clk);
            rst_s = rst_n; stall_s = stall;
            #1;
            if (!rst_s) begin
                pend_q.delete();
                d_q.delete();
                for (int i = 0; i < DPIPE - 1; i++) d_q.push_back(zero_exp());
                held = zero_exp();
            end else if (!stall_s) begin
                if (pend_q.size() == 0) begin
                    checkOutput("scoreboard_empty", 32'd0, 32'd1);
                end else begin
                    s = pend_q.pop_front();
                    d_q.push_back(s);
                    ds = d_q.pop_front();
                    held.a = s.a; held.b = s.b; held.abv = s.abv;
                    held.ha = s.ha; held.hb = s.hb;
                    held.d = ds.d; held.dv = ds.dv;
                end
            end
            checkOutput("Aselect", Aselect, held.a);
            checkOutput("Bselect", Bselect, held.b);
            checkOutput("ab_valid", {31'b0, ab_valid}, {31'b0, held.abv});
            checkOutput("haz_a", {31'b0, haz_a}, {31'b0, held.ha});
            checkOutput("haz_b", {31'b0, haz_b}, {31'b0, held.hb});
            checkOutput("Dselect", Dselect, held.d);
            checkOutput("d_valid", {31'b0, d_valid}, {31'b0, held.dv});
        end
    end

    initial begin
        logic [31:0] rnd;
        doReset();
        applyStimulus(32'h012A4020, 1'b0, 1'b1, 1'b0);
        repeat (4) applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h20050007, 1'b1, 1'b1, 1'b0);
        repeat (4) applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h012A4020, 1'b0, 1'b1, 1'b0);
        applyStimulus(32'h01004820, 1'b0, 1'b1, 1'b0);
        repeat (4) applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h012A4020, 1'b0, 1'b1, 1'b0);
        repeat (2) applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h01004820, 1'b0, 1'b1, 1'b0);
        repeat (4) applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h012A4020, 1'b0, 1'b1, 1'b0);
        repeat (2) applyStimulus(32'hFFFFFFFF, 1'b1, 1'b1, 1'b1);
        repeat (4) applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h00000020, 1'b0, 1'b1, 1'b0);
        applyStimulus(32'h00004020, 1'b0, 1'b1, 1'b0);
        repeat (4) applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h012A4020, 1'b0, 1'b1, 1'b0);
        applyStimulus(32'h20050007, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'h01004820, 1'b0, 1'b1, 1'b0);
        doReset();
        applyStimulus(32'h012A4020, 1'b0, 1'b1, 1'b0);
        repeat (4) applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 400; n++) begin
            rnd = $urandom;
            rnd[25:21] = 5'($urandom_range(0, 7));
            rnd[20:16] = 5'($urandom_range(0, 7));
            rnd[15:11] = 5'($urandom_range(0, 7));
            applyStimulus(rnd, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 4) == 0));
            if (n == 200) doReset();
        end
        repeat (DPIPE + 2) applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("scoreboard_drained", 32'(pend_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regsel_pipe_decoder.md
# regsel_pipe_decoder

Parametrised register-select decoder for the pipelined datapath. It turns the source and destination register fields of each issued instruction into one-hot select vectors for the register file read ports (A, B) and the write port (D). The destination select is carried through a stall-aware pipeline to write-back. The block also flags read-after-write hazards against destinations still in flight. It sits between instruction fetch and the register file, replacing the combinational single-port select decoders.

## Interface
- NREG, 32, number of registers; power of two, 2..64; AW = log2(NREG) is derived
- IW, 32, instruction bus width
- RS_LSB, 21, LSB of source-A field in ibus
- RT_LSB, 16, LSB of source-B field, and the destination field for I-type
- RD_LSB, 11, LSB of destination field for R-type
- DPIPE, 3, cycles from capture edge to write-back select; 2..6
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ibus  in  IW  instruction word
- in_valid  in  1  ibus holds a real instruction this cycle
- itype  in  1  1: destination is rt; 0: destination is rd
- stall  in  1  freeze every stage
- Aselect  out  NREG  one-hot read-port A select
- Bselect  out  NREG  one-hot read-port B select
- ab_valid  out  1  Aselect/Bselect are valid
- Dselect  out  NREG  one-hot write-port select at write-back
- d_valid  out  1  Dselect is valid
- haz_a, haz_b  out  1  source A/B matches an in-flight destination

## Operation
- Field extraction: rs = ibus[RS_LSB+AW-1:RS_LSB], and likewise rt and rd. Destination = itype ? rt : rd.
- Decode: onehot(x) = 1 << x, NREG bits wide, exactly one bit set.
- Capture stage: at a rising edge with stall=0:
  - Aselect <= onehot(rs), Bselect <= onehot(rt), ab_valid <= in_valid.
  - d[1] <= onehot(dest), with its valid bit <= in_valid.
- Destination pipeline: d[i] <= d[i-1] for i = 2..DPIPE. Dselect = d[DPIPE], d_valid = its valid bit.
- Bubbles: in_valid=0 loads all-zero selects and clears the valid bits. Bubbles never raise haz_a/haz_b.
- Hazards, registered at the capture edge:
  - haz_a <= in_valid & |(onehot(rs) & (d[1] | … | d[DPIPE-1])), using pre-edge stage contents. The same rule with rt gives haz_b.
  - The instruction currently at write-back (d[DPIPE]) is not a hazard, because the register file writes before it reads.
- Stall: every register, including the hazard flags, holds its value. ibus is ignored.
- Reset: all outputs and stage contents go to 0 immediately on rst_n low, in any state. Operation resumes on the first rising edge after rst_n goes high.

## Timing
- Aselect/Bselect/ab_valid/haz_*: 1 cycle after the capture edge.
- Dselect/d_valid: DPIPE cycles after the capture edge. Stalled cycles add to this 1:1.
- Stall and a new ibus in the same cycle: ibus is dropped. The source holds ibus until stall deasserts.
- Reset values: Aselect=Bselect=Dselect=0; ab_valid=d_valid=haz_a=haz_b=0.
- No combinational path from inputs to outputs.

## Configuration
- REGSEL_ZERO_SUPPRESS_EN defined: destination index 0 loads d[1]=0 with its valid bit unchanged, so Dselect is all-zero and writes to r0 are dropped. Sources equal to 0 never raise haz_a/haz_b.
- REGSEL_ZERO_SUPPRESS_EN undefined: index 0 is an ordinary register (Dselect bit 0 is set), and hazard detection covers it.

## Structure
- Package regsel_pkg holds:
  - the default field LSB constants (21/16/11);
  - the NREG/DPIPE legal-range constants;
  - the pipeline-stage struct {sel, valid}.
- Sub-module onehot_dec (parameter N): index in, one-hot out. It is instantiated three times (rs, rt, dest).

## Test plan
- Reset: drive rst_n=0 mid-stream with DPIPE=3 stages full -> all outputs 0 at once; after release, the first valid instruction appears normally.
- R-type: ibus=32'h012A4020 (rs=9, rt=10, rd=8), itype=0 -> next cycle Aselect=32'h200, Bselect=32'h400, ab_valid=1; 3 cycles after capture Dselect=32'h100, d_valid=1.
- I-type: ibus=32'h20050007, itype=1 -> Aselect=32'h1, Bselect=32'h20; Dselect=32'h20 at +3.
- Hazard: 32'h012A4020, then 32'h01004820 (rs=8) next cycle -> haz_a=1, haz_b=0 on the second instruction.
  - Insert two bubbles between them instead -> haz_a=0, because the first instruction is at write-back.
- Stall: assert stall for 2 cycles with the R-type in d[1] -> outputs frozen; Dselect=32'h100 arrives at +5.
- Zero suppress: ibus=32'h00000020 (rd=0) -> macro on: Dselect=0, d_valid=1. Macro off: Dselect=32'h1.
